// File: rtl/latch_pair.sv
// rtl/latch_pair.sv - paired D-enable and AND-OR set/reset storage channels on one clock
// Optional feature macro: LATCH_TRANSPARENT_EN (combinational d_out bypass while rw=1).
module latch_pair #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic             rw,
  input  logic [WIDTH-1:0] set,
  input  logic [WIDTH-1:0] reset,
  output logic [WIDTH-1:0] d_out,
  output logic [WIDTH-1:0] sr_out
);

  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] d_d;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  // Clear wins over set per bit, so a simultaneous request leaves the bit at 0.
  always_comb begin
    d_d  = rw ? data : d_q;
    sr_d = (sr_q | set) & ~reset;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q  <= '0;
      sr_q <= '0;
    end else begin
      d_q  <= d_d;
      sr_q <= sr_d;
    end
  end

`ifdef LATCH_TRANSPARENT_EN
  // Zero-latency view of data while enabled; d_q still captures it for after rw falls.
  assign d_out = rst ? '0 : (rw ? data : d_q);
`else
  assign d_out = d_q;
`endif

  assign sr_out = sr_q;

endmodule

// File: tb/tb_latch_pair.sv
// tb/tb_latch_pair.sv - table-driven self-checking bench for latch_pair (WIDTH=8)
module tb_latch_pair;

  localparam int W = 8;
  localparam int NV = 16;

  logic         clk;
  logic         rst;
  logic [W-1:0] data;
  logic         rw;
  logic [W-1:0] set;
  logic [W-1:0] reset;
  logic [W-1:0] d_out;
  logic [W-1:0] sr_out;

  int checks;
  int errors;

  typedef struct {
    logic         rst;
    logic [W-1:0] data;
    logic         rw;
    logic [W-1:0] set;
    logic [W-1:0] reset;
    logic [W-1:0] exp_d;
    logic [W-1:0] exp_sr;
  } vec_t;

  vec_t vecs [NV];

  latch_pair #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .data   (data),
    .rw     (rw),
    .set    (set),
    .reset  (reset),
    .d_out  (d_out),
    .sr_out (sr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pre_edge_d(input logic r, input logic w,
                                               input logic [W-1:0] dat,
                                               input logic [W-1:0] held);
`ifdef LATCH_TRANSPARENT_EN
    return r ? '0 : (w ? dat : held);
`else
    return held;
`endif
  endfunction

  logic [W-1:0] prev_d;
  logic [W-1:0] prev_sr;

  initial begin
    checks = 0;
    errors = 0;

    //          rst   data   rw    set    reset  exp_d  exp_sr
    vecs[0]  = '{1'b1, 8'hFF, 1'b1, 8'hFF, 8'h00, 8'h00, 8'h00};
    vecs[1]  = '{1'b0, 8'hA5, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, 8'hA5, 1'b1, 8'h00, 8'h00, 8'hA5, 8'h00};
    vecs[3]  = '{1'b0, 8'h3C, 1'b0, 8'h0F, 8'h00, 8'hA5, 8'h0F};
    vecs[4]  = '{1'b0, 8'h3C, 1'b1, 8'hF0, 8'h03, 8'h3C, 8'hFC};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h3C, 8'hFC};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 8'h01, 8'h01, 8'h3C, 8'hFC};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 8'hFF, 8'hFF, 8'h3C, 8'h00};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 8'h81, 8'h00, 8'h3C, 8'h81};
    vecs[9]  = '{1'b1, 8'h77, 1'b1, 8'hFF, 8'h00, 8'h00, 8'h00};
    vecs[10] = '{1'b0, 8'h77, 1'b1, 8'h00, 8'h00, 8'h77, 8'h00};
    vecs[11] = '{1'b0, 8'h11, 1'b0, 8'h00, 8'h00, 8'h77, 8'h00};
    vecs[12] = '{1'b0, 8'h11, 1'b1, 8'h00, 8'h00, 8'h11, 8'h00};
    vecs[13] = '{1'b0, 8'h22, 1'b0, 8'h00, 8'h00, 8'h11, 8'h00};
    vecs[14] = '{1'b0, 8'h80, 1'b1, 8'h40, 8'h00, 8'h80, 8'h40};
    vecs[15] = '{1'b0, 8'hFF, 1'b0, 8'h01, 8'h40, 8'h80, 8'h01};

    // Initial reset with pending write and set that must be discarded.
    rst = 1'b1; data = 8'hFF; rw = 1'b1; set = 8'hFF; reset = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_d", d_out, 8'h00);
    check("reset_sr", sr_out, 8'h00);
    prev_d  = 8'h00;
    prev_sr = 8'h00;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; data = vecs[i].data; rw = vecs[i].rw;
      set = vecs[i].set; reset = vecs[i].reset;
      #1;
      check($sformatf("pre_d[%0d]", i), d_out,
            pre_edge_d(vecs[i].rst, vecs[i].rw, vecs[i].data, prev_d));
      check($sformatf("pre_sr[%0d]", i), sr_out, prev_sr);
      @(posedge clk);
      #1;
      check($sformatf("post_d[%0d]", i), d_out, vecs[i].exp_d);
      check($sformatf("post_sr[%0d]", i), sr_out, vecs[i].exp_sr);
      prev_d  = vecs[i].exp_d;
      prev_sr = vecs[i].exp_sr;
    end

    // Long hold: rw=0 and no set/clear for several edges with changing data.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      rst = 1'b0; rw = 1'b0; data = 8'(k * 37 + 5); set = 8'h00; reset = 8'h00;
      @(posedge clk);
      #1;
      check($sformatf("hold_d[%0d]", k), d_out, 8'h80);
      check($sformatf("hold_sr[%0d]", k), sr_out, 8'h01);
    end

    // Reset held two cycles mid-operation, then released with rw=0: nothing reappears.
    @(negedge clk);
    rst = 1'b1; rw = 1'b1; data = 8'hC3; set = 8'hAA;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_d", d_out, 8'h00);
    check("midrst_sr", sr_out, 8'h00);
    @(negedge clk);
    rst = 1'b0; rw = 1'b0; set = 8'h00;
    @(posedge clk);
    #1;
    check("postrst_hold_d", d_out, 8'h00);
    check("postrst_hold_sr", sr_out, 8'h00);
    @(negedge clk);
    rw = 1'b1; data = 8'h5A; set = 8'h24;
    @(posedge clk);
    #1;
    check("postrst_write_d", d_out, 8'h5A);
    check("postrst_set_sr", sr_out, 8'h24);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
